// File: rtl/piso_pkg.sv
// Shared types and helpers for the piso_stream serialiser.
package piso_pkg;

   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;

   function automatic int cnt_w(input int width);
      return $clog2(width);
   endfunction

endpackage

// File: rtl/piso_bit_cnt.sv
// Bit-position counter for one frame: synchronous clear, count enable, and a flag at cnt==LAST.
module piso_bit_cnt
   import piso_pkg::*;
#(
   parameter int LAST = 7
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic en,
   output logic tc
);

   localparam int W = cnt_w(LAST + 1);

   logic [W-1:0] cnt;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (en)
         cnt <= cnt + W'(1);
   end

   assign tc = (cnt == W'(LAST));

endmodule

// File: rtl/piso_stream.sv
// Parallel-in/serial-out shifter with valid/ready word input and en-paced serial output.
// Define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_stream
   import piso_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] pi_data,
   input  logic             pi_valid,
   output logic             pi_ready,
   input  logic             en,
   output logic             so,
   output logic             so_valid,
   output logic             so_last,
   output logic             busy
);

   state_t           state, state_nx;
   logic [WIDTH-1:0] shreg;
   logic             init_q;
   logic             tc;
   logic             load;
   logic             adv;
`ifdef PISO_PARITY_EN
   logic             par_q;
`endif

   assign load = pi_valid & pi_ready;
   assign adv  = (state == SHIFT) & en & ~tc;

   piso_bit_cnt #(
      .LAST (WIDTH - 1)
   ) u_bit_cnt (
      .clk   (clk),
      .reset (reset),
      .clear (load),
      .en    (adv),
      .tc    (tc)
   );

   // Holds pi_ready low until the first edge after reset release.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         init_q <= 1'b0;
      else
         init_q <= 1'b1;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_nx;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         shreg <= '0;
      else if (load)
         shreg <= pi_data;
      else if (adv) begin
         if (MSB_FIRST)
            shreg <= {shreg[WIDTH-2:0], 1'b0};
         else
            shreg <= {1'b0, shreg[WIDTH-1:1]};
      end
   end

`ifdef PISO_PARITY_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         par_q <= 1'b0;
      else if (load)
         par_q <= ^pi_data;
   end
`endif

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (load)
               state_nx = SHIFT;
         end
         SHIFT: begin
            if (en && tc) begin
`ifdef PISO_PARITY_EN
               state_nx = PARITY;
`else
               state_nx = pi_valid ? SHIFT : IDLE;
`endif
            end
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            if (en)
               state_nx = pi_valid ? SHIFT : IDLE;
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   // Serial outputs decode registered state only; pi_ready alone looks at en.
   always_comb begin
      pi_ready = 1'b0;
      so       = 1'b0;
      so_valid = 1'b0;
      so_last  = 1'b0;
      busy     = 1'b0;
      case (state)
         IDLE: begin
            pi_ready = init_q;
         end
         SHIFT: begin
            busy     = 1'b1;
            so_valid = 1'b1;
            so       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
`ifndef PISO_PARITY_EN
            so_last  = tc;
            pi_ready = en & tc;
`endif
         end
`ifdef PISO_PARITY_EN
         PARITY: begin
            busy     = 1'b1;
            so_valid = 1'b1;
            so       = par_q;
            so_last  = 1'b1;
            pi_ready = en;
         end
`endif
         default: ;
      endcase
   end

endmodule

// File: tb/tb_piso_stream.sv
// Bench for piso_stream: MSB-first and LSB-first instances share stimulus, checked per cycle against a frame-list model.
module tb_piso_stream;

   localparam int W = 8;
`ifdef PISO_PARITY_EN
   localparam int FL = W + 1;
`else
   localparam int FL = W;
`endif

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         pi_valid = 1'b0;
   logic         en = 1'b0;
   logic [W-1:0] pi_data = '0;

   logic rdy_m, so_m, sov_m, last_m, busy_m;
   logic rdy_l, so_l, sov_l, last_l, busy_l;

   int checks = 0;
   int errors = 0;

   // Model: the frame being sent as an ordered bit list, plus the index of the bit on the line.
   bit   m_init = 1'b0;
   bit   m_act = 1'b0;
   int   m_idx = 0;
   bit   fm[FL];
   bit   fl[FL];

   logic obs_m, obs_l, obs_last, obs_v;

   always #5 clk = ~clk;

   piso_stream #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .pi_data(pi_data), .pi_valid(pi_valid), .pi_ready(rdy_m),
      .en(en), .so(so_m), .so_valid(sov_m), .so_last(last_m), .busy(busy_m)
   );

   piso_stream #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .pi_data(pi_data), .pi_valid(pi_valid), .pi_ready(rdy_l),
      .en(en), .so(so_l), .so_valid(sov_l), .so_last(last_l), .busy(busy_l)
   );

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic load_frame(input logic [W-1:0] d);
      for (int i = 0; i < W; i++) begin
         fm[i] = d[W-1-i];
         fl[i] = d[i];
      end
`ifdef PISO_PARITY_EN
      fm[W] = ^d;
      fl[W] = ^d;
`endif
      m_idx = 0;
      m_act = 1'b1;
   endtask

   // One clock: drive inputs, check outputs mid-cycle, advance the model at the edge.
   task automatic step(input logic v, input logic [W-1:0] d, input logic e);
      logic exp_rdy, exp_so_m, exp_so_l, exp_last, acc;
      pi_valid = v;
      pi_data  = d;
      en       = e;
      #3;
      exp_rdy  = !reset ? 1'b0 : (!m_act ? m_init : ((m_idx == FL - 1) && e));
      exp_so_m = m_act ? fm[m_idx] : 1'b0;
      exp_so_l = m_act ? fl[m_idx] : 1'b0;
      exp_last = m_act && (m_idx == FL - 1);
      check("ready_msb", 8'(rdy_m), 8'(exp_rdy));
      check("ready_lsb", 8'(rdy_l), 8'(exp_rdy));
      check("so_msb", 8'(so_m), 8'(exp_so_m));
      check("so_lsb", 8'(so_l), 8'(exp_so_l));
      check("valid_msb", 8'(sov_m), 8'(m_act));
      check("valid_lsb", 8'(sov_l), 8'(m_act));
      check("last_msb", 8'(last_m), 8'(exp_last));
      check("last_lsb", 8'(last_l), 8'(exp_last));
      check("busy_msb", 8'(busy_m), 8'(m_act));
      check("busy_lsb", 8'(busy_l), 8'(m_act));
      obs_m    = so_m;
      obs_l    = so_l;
      obs_last = last_m;
      obs_v    = sov_m;
      acc      = v && exp_rdy;
      @(posedge clk);
      if (reset) begin
         m_init = 1'b1;
         if (m_act && e) begin
            if (m_idx < FL - 1)
               m_idx++;
            else if (acc)
               load_frame(d);
            else
               m_act = 1'b0;
         end else if (!m_act && acc) begin
            load_frame(d);
         end
      end
      #1;
   endtask

   task automatic send_word(input logic [W-1:0] d, output logic [W-1:0] cm, output logic [W-1:0] cl);
      cm = '0;
      cl = '0;
      step(1'b1, d, 1'b1);
      for (int i = 0; i < W; i++) begin
         step(1'b0, '0, 1'b1);
         cm[W-1-i] = obs_m;
         cl[W-1-i] = obs_l;
      end
`ifdef PISO_PARITY_EN
      step(1'b0, '0, 1'b1);
      check("parity_bit", 8'(obs_m), 8'(^d));
      check("parity_last", 8'(obs_last), 8'd1);
`endif
      step(1'b0, '0, 1'b1);
   endtask

   initial begin
      logic [W-1:0] cm, cl;
      int run;

      // Reset held with a word offered: nothing may be accepted.
      for (int i = 0; i < 3; i++) step(1'b1, 8'hA5, 1'b1);
      reset = 1'b1;
      step(1'b1, 8'hA5, 1'b1);
      check("ready_after_release", 8'(rdy_m), 8'd1);

      send_word(8'hA5, cm, cl);
      check("a5_msb_seq", cm, 8'hA5);
      check("a5_lsb_seq", cl, 8'hA5);
      check("a5_idle_after", 8'(sov_m), 8'd0);

      send_word(8'h01, cm, cl);
      check("01_msb_seq", cm, 8'h01);
      check("01_lsb_seq", cl, 8'h80);

`ifdef PISO_PARITY_EN
      send_word(8'h07, cm, cl);
      check("07_msb_seq", cm, 8'h07);
`endif

      // Stall: en high one cycle in three.
      step(1'b1, 8'hF0, 1'b1);
      for (int k = 0; k < 80 && m_act; k++) step(1'b0, '0, 1'(k % 3 == 2));
      step(1'b0, '0, 1'b0);
      check("stall_idle", 8'(busy_m), 8'd0);

      // Back-to-back with pi_valid held high.
      step(1'b1, 8'h81, 1'b1);
      run = 0;
      for (int k = 0; k < FL; k++) begin
         step(1'b1, 8'h7E, 1'b1);
         if (obs_v) run++;
      end
      for (int k = 0; k < FL; k++) begin
         step(1'b0, '0, 1'b1);
         if (obs_v) run++;
      end
      check("b2b_contiguous", 8'(run), 8'(2 * FL));
      step(1'b0, '0, 1'b1);
      check("b2b_idle_after", 8'(sov_m), 8'd0);

      // Asynchronous reset in the middle of a frame.
      step(1'b1, 8'hFF, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      step(1'b0, '0, 1'b1);
      #1 reset = 1'b0;
      #1;
      check("midrst_so", 8'(so_m), 8'd0);
      check("midrst_busy", 8'(busy_m), 8'd0);
      check("midrst_valid", 8'(sov_l), 8'd0);
      check("midrst_ready", 8'(rdy_m), 8'd0);
      m_act  = 1'b0;
      m_init = 1'b0;
      step(1'b1, 8'hFF, 1'b1);
      reset = 1'b1;
      step(1'b0, '0, 1'b1);
      send_word(8'h3C, cm, cl);
      check("post_rst_msb", cm, 8'h3C);
      check("post_rst_lsb", cl, 8'h3C);

      // Random traffic against the model.
      for (int k = 0; k < 600; k++)
         step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 9) < 7));
      for (int k = 0; k < 60 && m_act; k++) step(1'b0, '0, 1'b1);
      check("final_idle", 8'(busy_m), 8'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/piso_stream.md
Name: piso_stream

Overview:
- Parametrised parallel-in/serial-out shifter; next generation of the team's single-bit PISO.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them one bit per enabled cycle.
- Supports a selectable shift order, a shift-enable stall input, and back-to-back frames with no idle bit.
- Sits between a word-level producer and a serial line driver; `en` is typically a baud or clock-divider tick.

Parameters:
- WIDTH, 8, data word width in bits; legal range 2..64.
- MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- pi_data  in  WIDTH  parallel word to serialise.
- pi_valid  in  1  producer has a word on pi_data.
- pi_ready  out  1  block can accept a word this cycle.
- en  in  1  shift enable; the serial output advances only when en=1.
- so  out  1  serial data bit.
- so_valid  out  1  so carries a frame bit.
- so_last  out  1  so carries the final bit of the frame.
- busy  out  1  a frame is in progress.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; shift register and bit counter clear.
  - so=0, so_valid=0, so_last=0, busy=0, pi_ready=0 while reset=0.
  - pi_ready=1 from the first clock edge after reset deasserts.
- State machine states: IDLE, SHIFT (plus PARITY with the optional feature). The state is held in a register.
- IDLE:
  - pi_ready=1, so_valid=0, so=0.
  - On an edge with pi_valid=1: the shift register loads pi_data, the counter is set to 0, and the state moves to SHIFT. en is ignored for acceptance.
- SHIFT:
  - busy=1 and so_valid=1.
  - so = shreg[WIDTH-1] when MSB_FIRST=1; so = shreg[0] when MSB_FIRST=0.
  - The first bit appears the cycle after acceptance (1-cycle latency).
  - Edge with en=1 and cnt<WIDTH-1: shift by one toward the output end, zero-fill, cnt++.
  - Edge with en=0: all state is held and so is stable. The stall may be of any length.
  - so_last=1 exactly when cnt==WIDTH-1.
- Last bit (cnt==WIDTH-1):
  - pi_ready = en; the block accepts the next word in the same cycle the last bit retires.
  - Edge with en=1 and pi_valid=1: load the new word, cnt=0, stay in SHIFT. There is no gap bit.
  - Edge with en=1 and pi_valid=0: go to IDLE.
- pi_ready=0 in every other SHIFT cycle. pi_valid while not ready is ignored; pi_data need not be held.
- Counter width is $clog2(WIDTH); the counter never wraps within a frame.
- so_valid, so and so_last are decoded from registers only (no combinational path from inputs). pi_ready depends combinationally on en only.
- Reset mid-frame: the frame is abandoned immediately and outputs take their reset values; no partial-frame resume.

Optional Feature:
- Macro: PISO_PARITY_EN.
- Defined:
  - Parity of the loaded word is captured at load.
  - After bit WIDTH-1, the FSM enters PARITY for one enabled bit; so = even parity (XOR of the word).
  - so_last moves from the last data bit to the parity bit.
  - Back-to-back acceptance moves to the PARITY cycle (pi_ready = en in PARITY).
  - Frame length is WIDTH+1.
- Undefined: no PARITY state and no parity register; frame length is WIDTH.

Decomposition:
- Package piso_pkg:
  - typedef enum state_t {IDLE, SHIFT, PARITY}.
  - Function cnt_w(width) returning $clog2(width).
- Sub-module piso_bit_cnt: counter with en, clear and terminal-count output (cnt==LAST). Instantiated once.
- Shift/FSM logic stays in piso_stream.

Test Plan:
- Reset values:
  - Stimulus: hold reset=0 for 3 cycles with pi_valid=1.
  - Response: so=0, so_valid=0, busy=0, pi_ready=0; nothing accepted. pi_ready=1 on the first edge after release.
- Single word, MSB first:
  - Stimulus: WIDTH=8, MSB_FIRST=1, en=1, pi_data=8'hA5 for one handshake.
  - Response: so = 1,0,1,0,0,1,0,1 on 8 consecutive cycles; so_last on the 8th bit only; then IDLE with so_valid=0.
- LSB first:
  - Stimulus: MSB_FIRST=0, pi_data=8'hA5.
  - Response: so = 1,0,1,0,0,1,0,1 reversed order, i.e. 1,0,1,0,0,1,0,1 read from bit 0 (A5 is palindromic). Repeat with 8'h01 → 1,0,0,0,0,0,0,0.
- en stall:
  - Stimulus: 8'hF0 with en toggling 1,0,0,1,…
  - Response: each bit held for exactly as many cycles as en=0 plus one. The bit sequence is unchanged and so_last lasts until the final en=1.
- Back-to-back:
  - Stimulus: pi_valid held high with 8'h81 then 8'h7E.
  - Response: 16 contiguous so_valid cycles with no gap; pi_ready high only on the two last-bit cycles; so_last on bits 8 and 16.
- Reset mid-frame, plus parity:
  - Reset stimulus: assert reset at bit 3 of 8'hFF. Response: so=0 and busy=0 immediately (async); the next word starts cleanly.
  - Parity stimulus: with PISO_PARITY_EN, send 8'h07. Response: 9 bits, parity bit = 1, so_last on the 9th bit.
